// File: rtl/click_emitter_pkg.sv
// Shared types and sizing helpers for the click emitter: FSM state encoding,
// default timing constants and counter width helpers.
package click_emitter_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPress   = 3'd1,
    StHold    = 3'd2,
    StRelease = 3'd3,
    StSettle  = 3'd4,
    StDone    = 3'd5
  } state_e;

  localparam int unsigned DefBounces   = 4;
  localparam int unsigned DefBounceCyc = 1;
  localparam int unsigned DefHoldCyc   = 50;
  localparam int unsigned DefGapCyc    = 8;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/click_emitter_phase_timer.sv
// Loadable down-counter; expire_o is high in the last cycle of a loaded interval.
module click_emitter_phase_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/click_emitter.sv
// Emulates a bouncy mechanical key: on accept, captures a U vector and plays press bounce,
// stable hold, release bounce and settle on count_o, then pulses done_o for one cycle.
module click_emitter
  import click_emitter_pkg::*;
#(
  parameter int unsigned UWidth    = 8,
  parameter int unsigned Bounces   = DefBounces,
  parameter int unsigned BounceCyc = DefBounceCyc,
  parameter int unsigned HoldCyc   = DefHoldCyc,
  parameter int unsigned GapCyc    = DefGapCyc
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [UWidth-1:0] u_in_i,
  output logic              ready_o,
  output logic [UWidth-1:0] u_o,
  output logic              count_o,
  output logic              done_o,
  output logic [2:0]        state_dbg_o
);

  localparam int unsigned NumLevels = 2 * Bounces - 2;
  localparam int unsigned LevelW    = cnt_width(NumLevels);
  localparam int unsigned TimerW    = cnt_width(max3(BounceCyc, HoldCyc, GapCyc));

  localparam logic [LevelW-1:0] LastLevel = LevelW'(NumLevels - 1);
  localparam logic [TimerW-1:0] BounceLd  = TimerW'(BounceCyc - 1);
  localparam logic [TimerW-1:0] HoldLd    = TimerW'(HoldCyc - 1);
  localparam logic [TimerW-1:0] GapLd     = TimerW'(GapCyc - 1);

  state_e            state_q, state_d;
  logic [LevelW-1:0] idx_q, idx_d;
  logic              count_q, count_d;
  logic              done_q, done_d;
  logic [UWidth-1:0] u_q, u_d;
  logic              tmr_load;
  logic [TimerW-1:0] tmr_value;
  logic              tmr_expire;

  click_emitter_phase_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    done_d    = 1'b0;
    u_d       = u_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          u_d      = u_in_i;
          count_d  = 1'b1;
          idx_d    = '0;
          tmr_load = 1'b1;
          // A single-bounce key has a clean edge, so go straight to the stable hold.
          if (NumLevels > 0) begin
            state_d   = StPress;
            tmr_value = BounceLd;
          end else begin
            state_d   = StHold;
            tmr_value = HoldLd;
          end
        end
      end
      StPress: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (idx_q == LastLevel) begin
            state_d   = StHold;
            count_d   = 1'b1;
            idx_d     = '0;
            tmr_value = HoldLd;
          end else begin
            idx_d     = idx_q + LevelW'(1);
            count_d   = idx_q[0];
            tmr_value = BounceLd;
          end
        end
      end
      StHold: begin
        if (tmr_expire) begin
          count_d  = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          if (NumLevels > 0) begin
            state_d   = StRelease;
            tmr_value = BounceLd;
          end else begin
            state_d   = StSettle;
            tmr_value = GapLd;
          end
        end
      end
      StRelease: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (idx_q == LastLevel) begin
            state_d   = StSettle;
            count_d   = 1'b0;
            idx_d     = '0;
            tmr_value = GapLd;
          end else begin
            idx_d     = idx_q + LevelW'(1);
            count_d   = ~idx_q[0];
            tmr_value = BounceLd;
          end
        end
      end
      StSettle: begin
        if (tmr_expire) begin
          state_d = StDone;
          done_d  = 1'b1;
          count_d = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        count_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      count_q <= 1'b0;
      done_q  <= 1'b0;
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      done_q  <= done_d;
      u_q     <= u_d;
    end
  end

  assign ready_o     = (state_q == StIdle);
  assign u_o         = u_q;
  assign count_o     = count_q;
  assign done_o      = done_q;
  assign state_dbg_o = state_q;

endmodule
